// File: rtl/term_pkg.sv
// Shared constants and types for the text terminal buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package term_pkg;

  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_HT       = 8'h09;
  localparam logic [7:0] ASC_LF       = 8'h0A;
  localparam logic [7:0] ASC_FF       = 8'h0C;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_t;

endpackage

// File: rtl/term_text_buffer_if.sv
// Byte-stream, renderer read port and status bundle for term_text_buffer.
// Latency: n/a (wiring only); rd_data lags rd_row/rd_col by one cycle.
// Backpressure: in_valid/in_ready; the read port never stalls.
// Ports: in_valid/in_data/in_ready (UART side), rd_row/rd_col/rd_data
// (renderer side), cur_row/cur_col/busy/scroll_pulse (status).
interface term_text_buffer_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 8
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [CHAR_W-1:0] rd_data;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic              busy;
  logic              scroll_pulse;

  // Source of bytes and read requests (UART + renderer).
  modport master (
    output in_valid, in_data, rd_row, rd_col,
    input  in_ready, rd_data, cur_row, cur_col, busy, scroll_pulse
  );

  // The buffer itself.
  modport slave (
    input  in_valid, in_data, rd_row, rd_col,
    output in_ready, rd_data, cur_row, cur_col, busy, scroll_pulse
  );
endinterface

// File: rtl/term_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Latency: o_rdat valid one cycle after i_raddr.
// Backpressure: none; both ports accept every cycle.
// Ports: clk, rst (clears the read register only), i_we/i_waddr/i_wdat,
// i_raddr, o_rdat.
module term_ram #(
  parameter int DEPTH  = 2400,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdat,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
  end

  // Non-blocking read of the array gives the pre-write value on a
  // same-address collision (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdat <= '0;
    else     r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/term_text_buffer.sv
// Character-cell screen buffer: interprets a byte stream, keeps cursor and a
// ring top-row pointer, and serves glyph codes to the renderer.
// Latency: accepted byte acts in its cycle; rd_data one cycle after address.
// Backpressure: in_ready low while a row or full-screen clear is running.
// Ports: clk, reset (async, active high), bus (term_text_buffer_if.slave).
// Optional: define TERM_TAB_EN to make 0x09 advance to the next 8-col stop.
module term_text_buffer
  import term_pkg::*;
#(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 30,
  parameter int                CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = CHAR_W'(8'h20)
) (
  input  logic                clk,
  input  logic                reset,
  term_text_buffer_if.slave   bus
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W + 1)'(ROWS);

  state_t           r_state;
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic [ROW_W-1:0] r_top;
  logic [ROW_W-1:0] r_clr_row;   // physical row being cleared
  logic [COL_W-1:0] r_clr_col;
  logic             r_scroll_pulse;

  // Logical to physical row: both operands < ROWS, so one conditional
  // subtract replaces the modulo.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= ROWS_EXT) sum = sum - ROWS_EXT;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  logic             w_accept;
  logic             w_is_print, w_is_lf, w_is_cr, w_is_bs, w_is_ff;
  logic             w_newline, w_scroll;
  logic [ROW_W-1:0] w_top_next;

  assign w_accept   = bus.in_valid && (r_state == IDLE);
  assign w_is_print = (bus.in_data >= ASC_PRINT_LO) && (bus.in_data <= ASC_PRINT_HI);
  assign w_is_lf    = (bus.in_data == ASC_LF);
  assign w_is_cr    = (bus.in_data == ASC_CR);
  assign w_is_bs    = (bus.in_data == ASC_BS);
  assign w_is_ff    = (bus.in_data == ASC_FF);
  assign w_newline  = w_accept && (w_is_lf || (w_is_print && r_cur_col == COL_LAST));
  assign w_scroll   = w_newline && (r_cur_row == ROW_LAST);
  assign w_top_next = (r_top == ROW_LAST) ? '0 : r_top + ROW_W'(1);

`ifdef TERM_TAB_EN
  logic             w_is_ht;
  logic [COL_W+3:0] w_tab_next;
  assign w_is_ht    = (bus.in_data == ASC_HT);
  // Extra headroom bits so the next stop never wraps for narrow screens.
  assign w_tab_next = ({4'b0, r_cur_col} | (COL_W + 4)'(7)) + (COL_W + 4)'(1);
`endif

  // Single write port: clears own it while busy, printable bytes otherwise.
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [CHAR_W-1:0] w_wdat;
  logic [ADDR_W-1:0] w_raddr;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdat  = BLANK;
    if (r_state != IDLE) begin
      w_we    = 1'b1;
      w_waddr = cell_addr(r_clr_row, r_clr_col);
    end else if (w_accept && w_is_print) begin
      w_we    = 1'b1;
      w_waddr = cell_addr(phys_row(r_cur_row, r_top), r_cur_col);
      w_wdat  = CHAR_W'(bus.in_data);
    end
  end

  assign w_raddr = cell_addr(phys_row(bus.rd_row, r_top), bus.rd_col);

  term_ram #(
    .DEPTH (CELLS),
    .WIDTH (CHAR_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (reset),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdat (w_wdat),
    .i_raddr(w_raddr),
    .o_rdat (bus.rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= CLR_ALL;
      r_cur_row      <= '0;
      r_cur_col      <= '0;
      r_top          <= '0;
      r_clr_row      <= '0;
      r_clr_col      <= '0;
      r_scroll_pulse <= 1'b0;
    end else begin
      r_scroll_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_print) begin
              r_cur_col <= (r_cur_col == COL_LAST) ? '0 : r_cur_col + COL_W'(1);
            end else if (w_is_lf || w_is_cr) begin
              r_cur_col <= '0;
            end else if (w_is_bs) begin
              if (r_cur_col != '0) r_cur_col <= r_cur_col - COL_W'(1);
            end else if (w_is_ff) begin
              r_cur_row <= '0;
              r_cur_col <= '0;
              r_top     <= '0;
              r_clr_row <= '0;
              r_clr_col <= '0;
              r_state   <= CLR_ALL;
`ifdef TERM_TAB_EN
            end else if (w_is_ht) begin
              if (w_tab_next >= (COL_W + 4)'(COLS)) r_cur_col <= COL_LAST;
              else                                  r_cur_col <= w_tab_next[COL_W-1:0];
`endif
            end
          end
          // The old top row becomes the new bottom row and is blanked.
          if (w_scroll) begin
            r_top          <= w_top_next;
            r_scroll_pulse <= 1'b1;
            r_clr_row      <= r_top;
            r_clr_col      <= '0;
            r_state        <= CLR_ROW;
          end else if (w_newline) begin
            r_cur_row <= r_cur_row + ROW_W'(1);
          end
        end
        CLR_ROW: begin
          if (r_clr_col == COL_LAST) r_state   <= IDLE;
          else                       r_clr_col <= r_clr_col + COL_W'(1);
        end
        CLR_ALL: begin
          if (r_clr_col == COL_LAST) begin
            r_clr_col <= '0;
            if (r_clr_row == ROW_LAST) r_state   <= IDLE;
            else                       r_clr_row <= r_clr_row + ROW_W'(1);
          end else begin
            r_clr_col <= r_clr_col + COL_W'(1);
          end
        end
        default: r_state <= CLR_ALL;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.cur_row      = r_cur_row;
  assign bus.cur_col      = r_cur_col;
  assign bus.scroll_pulse = r_scroll_pulse;

endmodule

// File: tb/tb_term_text_buffer.sv
// Self-checking bench for term_text_buffer against a logical-screen model.
// Latency: reads checked one cycle after the address is presented.
// Backpressure: bytes are held on in_valid until in_ready accepts them.
module tb_term_text_buffer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic reset;
  always #(PERIOD / 2) clk = ~clk;

  term_text_buffer_if #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W)) bus ();

  term_text_buffer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .CHAR_W(CHAR_W),
    .BLANK (8'h20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Logical screen model: row 0 is always the visible top row.
  logic [7:0] scr [ROWS][COLS];
  int mr, mc;
  logic [7:0] exp_q [$];
  int  pulses = 0;
  time last_acc;

  always @(negedge clk) if (bus.scroll_pulse === 1'b1) pulses++;

  initial begin
    #(PERIOD * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_nl();
    if (mr < ROWS - 1) mr++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mr][mc] = b;
      if (mc == COLS - 1) begin mc = 0; model_nl(); end
      else mc++;
    end else if (b == 8'h0A) begin
      mc = 0; model_nl();
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) mc--;
    end else if (b == 8'h0C) begin
      model_clear();
`ifdef TERM_TAB_EN
    end else if (b == 8'h09) begin
      mc = (mc / 8 + 1) * 8;
      if (mc >= COLS) mc = COLS - 1;
`endif
    end
  endtask

  // Presents a byte, holds it until accepted, then updates the model.
  task automatic send_byte(input logic [7:0] b);
    int w;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %h never accepted, in_ready=%b", b, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc = $time;
    #1;
    bus.in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Reads every cell; expected codes go through the scoreboard queue.
  task automatic scan_screen(input string tag);
    logic [7:0] got, exp;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        bus.rd_row = ROW_W'(r);
        bus.rd_col = COL_W'(c);
        exp_q.push_back(scr[r][c]);
        @(posedge clk);
        #1;
        got = bus.rd_data;
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL %s cell(%0d,%0d): got %h expected %h", tag, r, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_row   = '0;
    bus.rd_col   = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
    vectors++; if (bus.cur_row !== '0) begin miscompares++; $display("FAIL reset_cur_row: got %0d expected 0", bus.cur_row); end
    vectors++; if (bus.cur_col !== '0) begin miscompares++; $display("FAIL reset_cur_col: got %0d expected 0", bus.cur_col); end
    vectors++; if (bus.scroll_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_scroll_pulse: got %b expected 0", bus.scroll_pulse); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_idle(cyc);
    vectors++; if (cyc != ROWS * COLS) begin miscompares++; $display("FAIL reset_clear_cycles: got %0d expected %0d", cyc, ROWS * COLS); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b expected 1", bus.in_ready); end
    scan_screen("reset_blank");
  endtask

  task automatic test_cr_overwrite();
    send_byte("A"); send_byte("B"); send_byte(8'h0D); send_byte("C");
    vectors++; if (bus.cur_row !== ROW_W'(0) || bus.cur_col !== COL_W'(1)) begin miscompares++; $display("FAIL cr_cursor: got (%0d,%0d) expected (0,1)", bus.cur_row, bus.cur_col); end
    vectors++; if (scr[0][0] !== 8'h43 || scr[0][1] !== 8'h42) begin miscompares++; $display("FAIL cr_model: got %h %h expected 43 42", scr[0][0], scr[0][1]); end
    scan_screen("cr_overwrite");
  endtask

  task automatic test_row_fill();
    int p0;
    send_byte(8'h0D);
    p0 = pulses;
    for (int i = 0; i < COLS; i++) send_byte("x");
    @(negedge clk);
    vectors++; if (bus.cur_row !== ROW_W'(1) || bus.cur_col !== COL_W'(0)) begin miscompares++; $display("FAIL fill_cursor: got (%0d,%0d) expected (1,0)", bus.cur_row, bus.cur_col); end
    vectors++; if (pulses != p0) begin miscompares++; $display("FAIL fill_no_scroll: got %0d pulses expected 0", pulses - p0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL fill_busy: got %b expected 0", bus.busy); end
    scan_screen("row_fill");
  endtask

  task automatic test_ff();
    int cyc;
    send_byte(8'h0C);
    wait_idle(cyc);
    vectors++; if (cyc != ROWS * COLS) begin miscompares++; $display("FAIL ff_clear_cycles: got %0d expected %0d", cyc, ROWS * COLS); end
    vectors++; if (bus.cur_row !== '0 || bus.cur_col !== '0) begin miscompares++; $display("FAIL ff_cursor: got (%0d,%0d) expected (0,0)", bus.cur_row, bus.cur_col); end
    scan_screen("ff_blank");
  endtask

  task automatic test_scroll();
    int p0, cyc;
    send_byte("Q"); send_byte(8'h0D);
    p0 = pulses;
    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
    send_byte("Z");
    vectors++; if (pulses != p0) begin miscompares++; $display("FAIL scroll_early: got %0d pulses expected 0", pulses - p0); end
    send_byte(8'h0A);
    wait_idle(cyc);
    vectors++; if (cyc != COLS) begin miscompares++; $display("FAIL scroll_busy_cycles: got %0d expected %0d", cyc, COLS); end
    vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL scroll_pulses: got %0d expected 1", pulses - p0); end
    vectors++; if (bus.cur_row !== ROW_W'(ROWS - 1) || bus.cur_col !== '0) begin miscompares++; $display("FAIL scroll_cursor: got (%0d,%0d) expected (%0d,0)", bus.cur_row, bus.cur_col, ROWS - 1); end
    vectors++; if (scr[ROWS-2][0] !== 8'h5A || scr[0][0] !== 8'h20) begin miscompares++; $display("FAIL scroll_model: got %h %h expected 5a 20", scr[ROWS-2][0], scr[0][0]); end
    scan_screen("scroll");
  endtask

  task automatic test_bs();
    int cyc;
    send_byte(8'h0C);
    wait_idle(cyc);
    for (int i = 0; i < 5; i++) send_byte(8'h0A);
    send_byte(8'h08);
    vectors++; if (bus.cur_row !== ROW_W'(5) || bus.cur_col !== '0) begin miscompares++; $display("FAIL bs_col0: got (%0d,%0d) expected (5,0)", bus.cur_row, bus.cur_col); end
    send_byte("a"); send_byte("b"); send_byte(8'h08);
    vectors++; if (bus.cur_row !== ROW_W'(5) || bus.cur_col !== COL_W'(1)) begin miscompares++; $display("FAIL bs_back: got (%0d,%0d) expected (5,1)", bus.cur_row, bus.cur_col); end
    scan_screen("bs_no_erase");
  endtask

  task automatic test_ignored();
    int er, ec;
    er = mr;
    ec = mc;
    send_byte(8'h01); send_byte(8'h1B); send_byte(8'h7F); send_byte(8'h00);
    vectors++; if (bus.cur_row !== ROW_W'(er) || bus.cur_col !== COL_W'(ec)) begin miscompares++; $display("FAIL ignored_cursor: got (%0d,%0d) expected (%0d,%0d)", bus.cur_row, bus.cur_col, er, ec); end
`ifndef TERM_TAB_EN
    send_byte(8'h09);
    vectors++; if (bus.cur_col !== COL_W'(ec)) begin miscompares++; $display("FAIL ht_ignored: got %0d expected %0d", bus.cur_col, ec); end
`endif
  endtask

  task automatic test_hold_during_clr();
    int p0, cyc;
    time t_lf;
    send_byte(8'h0D);
    while (mr < ROWS - 1) send_byte(8'h0A);
    p0 = pulses;
    send_byte(8'h0A);
    t_lf = last_acc;
    send_byte("M");
    vectors++; if (last_acc - t_lf != time'((COLS + 1) * PERIOD)) begin miscompares++; $display("FAIL hold_accept_time: got %0t expected %0t", last_acc - t_lf, (COLS + 1) * PERIOD); end
    wait_idle(cyc);
    vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL hold_pulses: got %0d expected 1", pulses - p0); end
    vectors++; if (bus.cur_row !== ROW_W'(ROWS - 1) || bus.cur_col !== COL_W'(1)) begin miscompares++; $display("FAIL hold_cursor: got (%0d,%0d) expected (%0d,1)", bus.cur_row, bus.cur_col, ROWS - 1); end
    scan_screen("hold_during_clr");
  endtask

  task automatic test_back_to_back();
    int p0, cyc;
    time t0;
    send_byte(8'h0D);
    p0 = pulses;
    send_byte("a");
    t0 = last_acc;
    for (int i = 1; i < COLS; i++) send_byte(8'h61 + 8'(i % 26));
    vectors++; if (last_acc - t0 != time'((COLS - 1) * PERIOD)) begin miscompares++; $display("FAIL b2b_rate: got %0t expected %0t", last_acc - t0, (COLS - 1) * PERIOD); end
    wait_idle(cyc);
    vectors++; if (cyc != COLS) begin miscompares++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", cyc, COLS); end
    vectors++; if (pulses - p0 != 1) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 1", pulses - p0); end
    vectors++; if (bus.cur_row !== ROW_W'(ROWS - 1) || bus.cur_col !== '0) begin miscompares++; $display("FAIL b2b_cursor: got (%0d,%0d) expected (%0d,0)", bus.cur_row, bus.cur_col, ROWS - 1); end
    scan_screen("corner_wrap");
  endtask

`ifdef TERM_TAB_EN
  task automatic test_tab();
    send_byte(8'h0D);
    send_byte("a"); send_byte("b"); send_byte("c");
    send_byte(8'h09);
    vectors++; if (bus.cur_col !== COL_W'(8)) begin miscompares++; $display("FAIL tab_col3: got %0d expected 8", bus.cur_col); end
    send_byte(8'h0D);
    for (int i = 0; i < 77; i++) send_byte("t");
    send_byte(8'h09);
    vectors++; if (bus.cur_col !== COL_W'(79)) begin miscompares++; $display("FAIL tab_col77: got %0d expected 79", bus.cur_col); end
    scan_screen("tab_no_write");
  endtask
`endif

  initial begin
    test_reset();
    test_cr_overwrite();
    test_row_fill();
    test_ff();
    test_scroll();
    test_bs();
    test_ignored();
    test_hold_during_clr();
    test_back_to_back();
`ifdef TERM_TAB_EN
    test_tab();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
